delay_line_calib: RTL and testbench

Calibration controller that drives the `delay_i` select of a binary-tree multi-clock delay line, such as `delay_line_D4_O1_*`. On request it sweeps every delay code and waits for the line to settle at each one. It then samples a synchronised phase-detector bit and locks onto the first code where the detector's majority vote flips relative to code 0. The block sits in the clock-generation domain beside the delay line and hands the resulting code back to the delay line and to software.

---
 rtl/delay_calib_pkg.sv | 23 ++
 rtl/delay_calib_sampler.sv | 38 +++
 rtl/delay_line_calib.sv | 148 ++++++++++++++
 tb/tb_delay_line_calib.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/delay_calib_pkg.sv
// Shared types and width helpers for the delay-line calibration controller.
// Optional feature macro used by the top level: DELAY_CALIB_OVERRIDE_EN.
package delay_calib_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SAMPLE = 3'd2,
        DECIDE = 3'd3,
        DONE   = 3'd4
    } calib_state_e;

    // Settle counter only has to reach settle_cycles-1; keep at least one bit.
    function automatic int settle_cnt_width(input int settle_cycles);
        return (settle_cycles <= 1) ? 1 : $clog2(settle_cycles);
    endfunction

    // Ones counter must be able to hold num_samples itself.
    function automatic int sample_cnt_width(input int num_samples);
        return $clog2(num_samples) + 1;
    endfunction

endpackage

// File: rtl/delay_calib_sampler.sv
// Counts phase-detector samples and ones for one delay code and
// reports the majority vote (ties read as 0).
module delay_calib_sampler
    import delay_calib_pkg::*;
#(
    parameter int NumSamples = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    input  logic sample_i,
    output logic last_o,
    output logic maj_o
);

    localparam int CntW = sample_cnt_width(NumSamples);

    logic [CntW-1:0] r_sample_cnt;
    logic [CntW-1:0] r_ones_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sample_cnt <= '0;
            r_ones_cnt   <= '0;
        end else if (clear_i) begin
            r_sample_cnt <= '0;
            r_ones_cnt   <= '0;
        end else if (enable_i) begin
            r_sample_cnt <= r_sample_cnt + CntW'(1);
            r_ones_cnt   <= r_ones_cnt + CntW'(sample_i);
        end
    end

    assign last_o = enable_i && (r_sample_cnt == CntW'(NumSamples - 1));
    assign maj_o  = (r_ones_cnt > CntW'(NumSamples / 2));

endmodule

// File: rtl/delay_line_calib.sv
// Delay-line calibration controller: sweeps every delay code, votes on the
// phase detector and locks to the first code whose vote differs from code 0.
// Build option DELAY_CALIB_OVERRIDE_EN adds an IDLE-time manual code override.
module delay_line_calib
    import delay_calib_pkg::*;
#(
    parameter int DelayWidth   = 4,
    parameter int SettleCycles = 8,
    parameter int NumSamples   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  sample_i,
`ifdef DELAY_CALIB_OVERRIDE_EN
    input  logic                  override_en_i,
    input  logic [DelayWidth-1:0] override_code_i,
`endif
    output logic [DelayWidth-1:0] delay_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  found_o,
    output logic [DelayWidth-1:0] code_o,
    output logic [2:0]            state_o
);

    localparam int SettleW = settle_cnt_width(SettleCycles);

    calib_state_e          r_state,      w_state_next;
    logic [SettleW-1:0]    r_settle_cnt, w_settle_next;
    logic [DelayWidth-1:0] r_cur_code,   w_cur_code_next;
    logic [DelayWidth-1:0] r_code,       w_code_next;
    logic [DelayWidth-1:0] r_delay,      w_delay_next;
    logic                  r_ref_maj,    w_ref_maj_next;
    logic                  r_found,      w_found_next;
    logic [DelayWidth-1:0] w_idle_delay;
    logic                  w_last;
    logic                  w_maj;

    delay_calib_sampler #(
        .NumSamples (NumSamples)
    ) u_sampler (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (r_state == APPLY),
        .enable_i (r_state == SAMPLE),
        .sample_i (sample_i),
        .last_o   (w_last),
        .maj_o    (w_maj)
    );

`ifdef DELAY_CALIB_OVERRIDE_EN
    assign w_idle_delay = override_en_i ? override_code_i : r_code;
`else
    assign w_idle_delay = r_code;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_settle_next   = r_settle_cnt;
        w_cur_code_next = r_cur_code;
        w_code_next     = r_code;
        w_delay_next    = r_delay;
        w_ref_maj_next  = r_ref_maj;
        w_found_next    = r_found;
        case (r_state)
            IDLE: begin
                w_delay_next = w_idle_delay;
                if (start_i) begin
                    w_state_next    = APPLY;
                    w_cur_code_next = '0;
                    w_delay_next    = '0;
                    w_settle_next   = '0;
                    w_found_next    = 1'b0;
                end
            end
            APPLY: begin
                if (r_settle_cnt == SettleW'(SettleCycles - 1)) begin
                    w_state_next  = SAMPLE;
                    w_settle_next = '0;
                end else begin
                    w_settle_next = r_settle_cnt + SettleW'(1);
                end
            end
            SAMPLE: begin
                if (w_last) begin
                    w_state_next = DECIDE;
                end
            end
            DECIDE: begin
                // Code 0 only records the reference vote; it can never be the lock point.
                if (r_cur_code == '0) begin
                    w_ref_maj_next = w_maj;
                end
                if ((r_cur_code != '0) && (w_maj != r_ref_maj)) begin
                    w_code_next  = r_cur_code;
                    w_found_next = 1'b1;
                    w_delay_next = r_cur_code;
                    w_state_next = DONE;
                end else if (r_cur_code == '1) begin
                    w_code_next  = '1;
                    w_found_next = 1'b0;
                    w_delay_next = '1;
                    w_state_next = DONE;
                end else begin
                    w_cur_code_next = r_cur_code + DelayWidth'(1);
                    w_delay_next    = r_cur_code + DelayWidth'(1);
                    w_state_next    = APPLY;
                end
            end
            DONE: begin
                w_delay_next = w_idle_delay;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_cur_code   <= '0;
            r_code       <= '0;
            r_delay      <= '0;
            r_ref_maj    <= 1'b0;
            r_found      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
            r_cur_code   <= w_cur_code_next;
            r_code       <= w_code_next;
            r_delay      <= w_delay_next;
            r_ref_maj    <= w_ref_maj_next;
            r_found      <= w_found_next;
        end
    end

    assign delay_o = r_delay;
    assign code_o  = r_code;
    assign found_o = r_found;
    assign busy_o  = (r_state == APPLY) || (r_state == SAMPLE) || (r_state == DECIDE);
    assign done_o  = (r_state == DONE);
    assign state_o = r_state;

endmodule

// File: tb/tb_delay_line_calib.sv
// Self-checking bench for delay_line_calib using default parameters
// (16 codes, 25 cycles per code).
module tb_delay_line_calib;

    localparam int DW = 4;

    typedef struct {
        int   pat;
        int   exp_code;
        logic exp_found;
        int   exp_done;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sample = 1'b0;
    logic [DW-1:0] delay;
    logic          busy;
    logic          done;
    logic          found;
    logic [DW-1:0] code;
    logic [2:0]    state;
`ifdef DELAY_CALIB_OVERRIDE_EN
    logic          ovr_en = 1'b0;
    logic [DW-1:0] ovr_code = '0;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q[$];
    vec_t vecs[6];

    delay_line_calib dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .sample_i        (sample),
`ifdef DELAY_CALIB_OVERRIDE_EN
        .override_en_i   (ovr_en),
        .override_code_i (ovr_code),
`endif
        .delay_o         (delay),
        .busy_o          (busy),
        .done_o          (done),
        .found_o         (found),
        .code_o          (code),
        .state_o         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Phase-detector stimulus per pattern, delay code and sample index.
    function automatic logic pat_bit(input int pat, input int c, input int idx);
        case (pat)
            0:       return (c >= 6);
            1:       return 1'b1;
            2:       return (c < 3) ? 1'b1 : ((c == 3) ? ((idx % 2) == 1) : 1'b0);
            3:       return 1'b0;
            4:       return (c < 9);
            5:       return (c == 0) ? (idx < 9) : (idx < 8);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int            t;
        int            done_t;
        logic          sweep_ok;
        logic [DW:0]   exp;
        logic [DW-1:0] act_code;
        logic          act_found;
        act_code  = 'x;
        act_found = 1'bx;
        exp_q.push_back({v.exp_found, DW'(v.exp_code)});
        @(negedge clk);
        start  = 1'b1;
        sample = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d_busy_first", id), busy, 1);
        check($sformatf("v%0d_delay_first", id), delay, 0);
        check($sformatf("v%0d_found_cleared", id), found, 0);
        done_t   = -1;
        sweep_ok = 1'b1;
        t        = 0;
        while (done_t < 0 && t < 500) begin
            if (done) begin
                done_t    = t;
                act_code  = code;
                act_found = found;
            end else begin
                if (!busy || delay !== DW'(t / 25)) sweep_ok = 1'b0;
                sample = pat_bit(v.pat, t / 25, (t % 25) - 8);
                @(negedge clk);
                t++;
            end
        end
        check($sformatf("v%0d_done_cycle", id), done_t + 1, v.exp_done);
        check($sformatf("v%0d_sweep_delay", id), sweep_ok, 1);
        exp = exp_q.pop_front();
        check($sformatf("v%0d_code", id), act_code, exp[DW-1:0]);
        check($sformatf("v%0d_found", id), act_found, exp[DW]);
        check($sformatf("v%0d_busy_at_done", id), busy, 0);
        sample = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_idle_delay", id), delay, exp[DW-1:0]);
        check($sformatf("v%0d_done_single", id), done, 0);
        check($sformatf("v%0d_idle_state", id), state, 0);
    endtask

    initial begin
        logic quiet;
        vecs[0] = '{pat: 0, exp_code: 6,  exp_found: 1'b1, exp_done: 176};
        vecs[1] = '{pat: 1, exp_code: 15, exp_found: 1'b0, exp_done: 401};
        vecs[2] = '{pat: 2, exp_code: 3,  exp_found: 1'b1, exp_done: 101};
        vecs[3] = '{pat: 3, exp_code: 15, exp_found: 1'b0, exp_done: 401};
        vecs[4] = '{pat: 4, exp_code: 9,  exp_found: 1'b1, exp_done: 251};
        vecs[5] = '{pat: 5, exp_code: 1,  exp_found: 1'b1, exp_done: 51};

        // Reset, then idle without a start.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_delay", delay, 0);
        check("rst_code", code, 0);
        check("rst_found", found, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", state, 0);
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy || delay !== '0) quiet = 1'b0;
        end
        check("idle_quiet", quiet, 1);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Extra starts mid-sweep, then asynchronous reset at code 4.
        @(negedge clk);
        start  = 1'b1;
        sample = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 103; t++) begin
            start = (t == 53 || t == 54);
            if (t == 56) begin
                check("extra_start_busy", busy, 1);
                check("extra_start_delay", delay, 2);
            end
            @(negedge clk);
        end
        check("pre_reset_delay", delay, 4);
        rst_n = 1'b0;
        #1;
        check("abort_delay", delay, 0);
        check("abort_code", code, 0);
        check("abort_found", found, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_state", state, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (450) begin
            @(negedge clk);
            if (done || busy) quiet = 1'b0;
        end
        check("no_done_after_abort", quiet, 1);

`ifdef DELAY_CALIB_OVERRIDE_EN
        ovr_en   = 1'b1;
        ovr_code = 4'd9;
        @(negedge clk);
        @(negedge clk);
        check("ovr_delay", delay, 9);
        check("ovr_code_held", code, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ovr_start_delay", delay, 0);
        check("ovr_start_busy", busy, 1);
        repeat (30) @(negedge clk);
        check("ovr_sweep_code1", delay, 1);
        rst_n = 1'b0;
        ovr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ovr_off_delay", delay, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
